burst_mem_responder: RTL

- Memory-side responder for the 4-beat, 64-bit burst protocol driven by the LLC cacheline adaptor.
- Accepts line-aligned read/write requests, waits a programmable latency, then transfers 4 beats with a per-beat response strobe.
- Backed by an internal line array.
- Used as the physical-memory model in cache and adaptor testbenches, and as a synthesizable on-chip line store.

---
 rtl/burst_mem_pkg.sv | 34 +++
 rtl/burst_line_store.sv | 30 +++
 rtl/burst_mem_responder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/burst_mem_pkg.sv
// Shared types and constants for the 4-beat, 64-bit line burst protocol.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package burst_mem_pkg;

    localparam int LINE_W      = 256;
    localparam int BURST_W     = 64;
    localparam int BEATS       = 4;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Extract beat k of a line (beat 0 is the least significant 64 bits).
    function automatic logic [BURST_W-1:0] get_beat(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        k);
        return line[k*BURST_W +: BURST_W];
    endfunction

    // Return a copy of a line with beat k replaced.
    function automatic logic [LINE_W-1:0] put_beat(input logic [LINE_W-1:0]  line,
                                                   input logic [1:0]         k,
                                                   input logic [BURST_W-1:0] beat);
        logic [LINE_W-1:0] res;
        res = line;
        res[k*BURST_W +: BURST_W] = beat;
        return res;
    endfunction

endpackage

// File: rtl/burst_line_store.sv
// Line array: DEPTH_LINES x 256-bit, combinational read, synchronous full-line write.
// Latency: read 0 cycles, write visible the cycle after the we edge.
// Backpressure: none; a write is accepted on every edge with we=1.
module burst_line_store
    import burst_mem_pkg::*;
#(
    parameter int DEPTH_LINES = 64
)(
    input  logic                           clk,
    input  logic [$clog2(DEPTH_LINES)-1:0] ridx,
    output logic [LINE_W-1:0]              rdata,
    input  logic                           we,
    input  logic [$clog2(DEPTH_LINES)-1:0] widx,
    input  logic [LINE_W-1:0]              wdata
);

    // Contents are never reset; they start at zero so simulations begin from a known image.
    logic [LINE_W-1:0] lines_q [DEPTH_LINES] = '{default: '0};

    // Asynchronous read of the addressed line.
    assign rdata = lines_q[ridx];

    // Whole-line write so a committed burst lands atomically.
    always_ff @(posedge clk) begin
        if (we) begin
            lines_q[widx] <= wdata;
        end
    end

endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder: accepts a line request, waits LATENCY cycles, moves 4 beats.
// Latency: first resp_o beat registered LATENCY+1 edges after acceptance; 4 contiguous beats.
// Backpressure: none; the initiator must hold the request and consume/produce a beat every resp_o cycle.
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 64
)(
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic               resp_o,
    output logic               error_o
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               op_wr_q, op_wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         beat_q, beat_d;
    logic               resp_q, resp_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               error_q, error_d;
    logic [LINE_W-1:0]  rbuf_q, rbuf_d;
    logic [LINE_W-1:0]  wbuf_q, wbuf_d;

    logic [IDX_W-1:0]   req_idx;
    logic [LINE_W-1:0]  rd_line;
    logic               commit;
    logic               unused_addr;

    // Offset bits and aliasing upper bits take no part in line selection.
    assign req_idx     = address_i[OFFSET_BITS +: IDX_W];
    assign unused_addr = ^{address_i[31:OFFSET_BITS+IDX_W], address_i[OFFSET_BITS-1:0]};

    burst_line_store #(
        .DEPTH_LINES (DEPTH_LINES)
    ) u_store (
        .clk   (clk),
        .ridx  (req_idx),
        .rdata (rd_line),
        .we    (commit & ~rst),
        .widx  (idx_q),
        .wdata (wbuf_d)
    );

    // Next-state and output logic; resp_d/burst_d default low so burst_o is 0 outside beats.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_wr_d = op_wr_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        resp_d  = 1'b0;
        burst_d = '0;
        error_d = error_q;
        rbuf_d  = rbuf_q;
        wbuf_d  = wbuf_q;
        commit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (read_i || write_i) begin
                    idx_d   = req_idx;
                    op_wr_d = write_i;
                    cnt_d   = CNT_W'(LATENCY);
                    beat_d  = 2'd0;
                    // Conflicting request resolves as a write but is flagged.
                    if (read_i && write_i) begin
                        error_d = 1'b1;
                    end
                    if (!write_i) begin
                        rbuf_d = rd_line;
                    end
                    state_d = (LATENCY == 0) ? BURST : WAIT;
                end
            end

            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = BURST;
                end
            end

            BURST: begin
                if (!resp_q) begin
                    // First edge in BURST launches beat 0.
                    resp_d  = 1'b1;
                    beat_d  = 2'd0;
                    burst_d = op_wr_q ? '0 : get_beat(rbuf_q, 2'd0);
                end else begin
                    if (op_wr_q) begin
                        wbuf_d = put_beat(wbuf_q, beat_q, burst_i);
                    end
                    if (beat_q == 2'd3) begin
                        // Last beat ends here; a write commits the assembled line in one go.
                        commit  = op_wr_q;
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 2'd1;
                        resp_d  = 1'b1;
                        burst_d = op_wr_q ? '0 : get_beat(rbuf_q, beat_q + 2'd1);
                    end
                end
            end

            DONE: begin
                // A still-held level request must fall before anything new is accepted.
                if (!read_i && !write_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            op_wr_q <= 1'b0;
            cnt_q   <= '0;
            beat_q  <= '0;
            resp_q  <= 1'b0;
            burst_q <= '0;
            error_q <= 1'b0;
            rbuf_q  <= '0;
            wbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_wr_q <= op_wr_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            resp_q  <= resp_d;
            burst_q <= burst_d;
            error_q <= error_d;
            rbuf_q  <= rbuf_d;
            wbuf_q  <= wbuf_d;
        end
    end

    assign resp_o  = resp_q;
    assign burst_o = burst_q;
    assign error_o = error_q;

endmodule
